// File: rtl/neopixel_pkg.sv
// Shared definitions for the NeoPixel strand driver: channel encoding,
// controller states and default WS2812 timing at a 50 MHz clock.
package neopixel_pkg;

    // Encoding of the color_index input; 3 selects no channel.
    typedef enum logic [1:0] {
        RED      = 2'd0,
        BLUE     = 2'd1,
        GREEN    = 2'd2,
        RESERVED = 2'd3
    } color_e;

    // Frame controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SENDING = 2'd1,
        LATCH   = 2'd2
    } state_e;

    // Default timing in clock cycles (20 ns each).
    localparam int DEF_NUM_PIXELS   = 5;
    localparam int DEF_T0H          = 18;
    localparam int DEF_T1H          = 35;
    localparam int DEF_TBIT         = 63;
    localparam int DEF_LATCH_CYCLES = 2500;

    // Each pixel is shifted out as G[7:0], R[7:0], B[7:0].
    localparam int BITS_PER_PIXEL = 24;

endpackage

// File: rtl/neopixel_bit_encoder.sv
// Generates one WS2812 bit cell: data high for T1H (bit=1) or T0H (bit=0)
// cycles, then low until TBIT cycles have elapsed. done_o marks the last
// cycle of the cell so the caller can issue the next start back-to-back.
module neopixel_bit_encoder
    import neopixel_pkg::*;
#(
    parameter int T0H  = DEF_T0H,
    parameter int T1H  = DEF_T1H,
    parameter int TBIT = DEF_TBIT
) (
    input  logic clock,
    input  logic reset,
    input  logic start_i,
    input  logic bit_i,
    output logic data_o,
    output logic done_o
);

    localparam int CW = (TBIT > 1) ? $clog2(TBIT) : 1;
    localparam logic [CW-1:0] LAST_C = CW'(TBIT - 1);
    localparam logic [CW-1:0] T0H_C  = CW'(T0H);
    localparam logic [CW-1:0] T1H_C  = CW'(T1H);

    logic          busy_q, busy_d;
    logic          bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          data_q, data_d;
    logic [CW-1:0] thigh;

    // Cell sequencing: start reloads the cell, otherwise count through it.
    always_comb begin
        busy_d = busy_q;
        bit_d  = bit_q;
        cnt_d  = cnt_q;
        data_d = data_q;
        done_o = busy_q && (cnt_q == LAST_C);
        thigh  = bit_q ? T1H_C : T0H_C;
        if (start_i) begin
            busy_d = 1'b1;
            bit_d  = bit_i;
            cnt_d  = '0;
            data_d = 1'b1;
        end else if (done_o) begin
            busy_d = 1'b0;
            cnt_d  = '0;
            data_d = 1'b0;
        end else if (busy_q) begin
            cnt_d  = cnt_q + 1'b1;
            data_d = (cnt_d < thigh);
        end
    end

    // Cell registers; data_q drives the strand directly so it never glitches.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= 1'b0;
            bit_q  <= 1'b0;
            cnt_q  <= '0;
            data_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            bit_q  <= bit_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/neopixel_strand_driver.sv
// Double-buffered WS2812 strand driver. Loads always land in the shadow
// buffer; an accepted send_it snapshots shadow into the active buffer, which
// is then shifted out gaplessly, followed by a low latch period.
module neopixel_strand_driver
    import neopixel_pkg::*;
#(
    parameter int NUM_PIXELS   = DEF_NUM_PIXELS,
    parameter int T0H          = DEF_T0H,
    parameter int T1H          = DEF_T1H,
    parameter int TBIT         = DEF_TBIT,
    parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
    localparam int PW          = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [7:0]    color_level,
    input  logic [1:0]    color_index,
    input  logic [PW-1:0] pixel_index,
    input  logic          load_color,
    input  logic          send_it,
    output logic          neo_data,
    output logic          ready_to_load,
    output logic          ready_to_send,
    output logic          frame_done
);

    localparam int TOTAL_BITS = BITS_PER_PIXEL * NUM_PIXELS;
    localparam int BW         = $clog2(TOTAL_BITS);
    localparam int LW         = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [BW-1:0] LAST_BIT   = BW'(TOTAL_BITS - 1);
    localparam logic [LW-1:0] LAST_LATCH = LW'(LATCH_CYCLES - 1);
    localparam logic [PW:0]   NP_LIMIT   = (PW + 1)'(NUM_PIXELS);

    // Pixel words are {G, R, B} so bit 23 is the first bit on the wire.
    logic [23:0] shadow_q [NUM_PIXELS];
    logic [23:0] active_q [NUM_PIXELS];

    state_e        state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [PW-1:0] pix_cnt_q, pix_cnt_d;
    logic [4:0]    sub_cnt_q, sub_cnt_d;
    logic [LW-1:0] latch_cnt_q, latch_cnt_d;

    logic load_ok;
    logic copy_en;
    logic enc_start;
    logic enc_bit;
    logic enc_data;
    logic enc_done;

    assign load_ok = load_color && (color_index != RESERVED)
                     && ({1'b0, pixel_index} < NP_LIMIT);

    // Shadow buffer: writable in every state; bad channel/pixel is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PIXELS; i++) shadow_q[i] <= '0;
        end else if (load_ok) begin
            case (color_e'(color_index))
                GREEN:   shadow_q[pixel_index][23:16] <= color_level;
                RED:     shadow_q[pixel_index][15:8]  <= color_level;
                BLUE:    shadow_q[pixel_index][7:0]   <= color_level;
                default: ;
            endcase
        end
    end

    // Active buffer: snapshot of shadow taken when a frame starts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PIXELS; i++) active_q[i] <= '0;
        end else if (copy_en) begin
            for (int i = 0; i < NUM_PIXELS; i++) active_q[i] <= shadow_q[i];
        end
    end

    // Frame controller: next state, counters and handshake outputs.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        sub_cnt_d     = sub_cnt_q;
        latch_cnt_d   = latch_cnt_q;
        copy_en       = 1'b0;
        enc_start     = 1'b0;
        enc_bit       = 1'b0;
        ready_to_send = 1'b0;
        frame_done    = 1'b0;
        case (state_q)
            IDLE: begin
                ready_to_send = 1'b1;
                if (send_it) begin
                    // First bit comes straight from shadow: active is only
                    // written at this same edge.
                    copy_en   = 1'b1;
                    enc_start = 1'b1;
                    enc_bit   = shadow_q[0][23];
                    bit_cnt_d = '0;
                    pix_cnt_d = '0;
                    sub_cnt_d = '0;
                    state_d   = SENDING;
                end
            end
            SENDING: begin
                if (enc_done) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        latch_cnt_d = '0;
                        state_d     = LATCH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (sub_cnt_q == 5'd23) begin
                            sub_cnt_d = '0;
                            pix_cnt_d = pix_cnt_q + 1'b1;
                        end else begin
                            sub_cnt_d = sub_cnt_q + 1'b1;
                        end
                        enc_start = 1'b1;
                        enc_bit   = active_q[pix_cnt_d][5'd23 - sub_cnt_d];
                    end
                end
            end
            LATCH: begin
                if (latch_cnt_q == LAST_LATCH) begin
                    frame_done  = 1'b1;
                    latch_cnt_d = '0;
                    state_d     = IDLE;
                end else begin
                    latch_cnt_d = latch_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state and counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            pix_cnt_q   <= '0;
            sub_cnt_q   <= '0;
            latch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            pix_cnt_q   <= pix_cnt_d;
            sub_cnt_q   <= sub_cnt_d;
            latch_cnt_q <= latch_cnt_d;
        end
    end

    neopixel_bit_encoder #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT)
    ) u_bit_encoder (
        .clock   (clock),
        .reset   (reset),
        .start_i (enc_start),
        .bit_i   (enc_bit),
        .data_o  (enc_data),
        .done_o  (enc_done)
    );

    assign neo_data      = enc_data;
    assign ready_to_load = 1'b1;

endmodule

// File: doc/neopixel_strand_driver.md
NEOPIXEL_STRAND_DRIVER -- requirements
Module: neopixel_strand_driver

Interface
REQ-001 The block SHALL have parameter NUM_PIXELS, default 5: number of LEDs on the strand, legal range 1..256.
REQ-002 The block SHALL have parameter T0H, default 18: high cycles for a 0 bit.
REQ-003 The block SHALL have parameter T1H, default 35: high cycles for a 1 bit.
REQ-004 The block SHALL have parameter TBIT, default 63: total cycles per bit, with T0H < T1H < TBIT.
REQ-005 The block SHALL have parameter LATCH_CYCLES, default 2500: low cycles after a frame (50 us at 50 MHz).
REQ-006 The block SHALL have port clock, input, 1 bit: 50 MHz clock; all logic is on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-008 The block SHALL have port color_level, input, 8 bits: intensity to load.
REQ-009 The block SHALL have port color_index, input, 2 bits: 0 = R, 1 = B, 2 = G, 3 = reserved.
REQ-010 The block SHALL have port pixel_index, input, PW = max(1,$clog2(NUM_PIXELS)) bits: target LED.
REQ-011 The block SHALL have port load_color, input, 1 bit: write request, one cycle.
REQ-012 The block SHALL have port send_it, input, 1 bit: frame start request.
REQ-013 The block SHALL have port neo_data, output, 1 bit: serial strand data.
REQ-014 The block SHALL have port ready_to_load, output, 1 bit: a load_color is accepted this cycle.
REQ-015 The block SHALL have port ready_to_send, output, 1 bit: a send_it is accepted this cycle.
REQ-016 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when the latch period ends.

Function
REQ-017 The block SHALL be double-buffered: a shadow buffer of NUM_PIXELS x {G,R,B} and an active buffer of the same size.
REQ-018 ready_to_load SHALL be 1 in every state, so loads are accepted during SENDING and LATCH and do not disturb the frame in flight.
REQ-019 A load with load_color=1 SHALL write color_level into shadow[pixel_index][channel] at the clock edge.
REQ-020 A load with color_index=3 or pixel_index>=NUM_PIXELS SHALL be ignored with no state change.
REQ-021 The FSM SHALL have states IDLE, SENDING and LATCH; ready_to_send SHALL be 1 only in IDLE.
REQ-022 In IDLE, send_it=1 SHALL copy shadow to active and move to SENDING on the next edge.
REQ-023 A load in the same cycle as an accepted send_it SHALL update shadow only; the frame SHALL carry the pre-load value.
REQ-024 send_it outside IDLE SHALL be ignored and not queued.
REQ-025 Serial order SHALL be pixel 0 first, each pixel as G[7:0], R[7:0], B[7:0], MSB first: 24*NUM_PIXELS bits.
REQ-026 Each bit SHALL last exactly TBIT cycles: neo_data high for T1H (bit = 1) or T0H (bit = 0) cycles, then low for the rest.
REQ-027 neo_data SHALL rise on the first cycle in SENDING (one cycle after send_it is accepted).
REQ-028 Frames SHALL be gapless: the total SENDING duration is exactly 24*NUM_PIXELS*TBIT cycles.
REQ-029 After the last bit the FSM SHALL enter LATCH, hold neo_data=0 for LATCH_CYCLES cycles, pulse frame_done on the last LATCH cycle, then return to IDLE.
REQ-030 neo_data SHALL be registered and glitch-free, and SHALL be 0 outside SENDING.

Reset
REQ-031 Asserting reset SHALL force IDLE in any state, including mid-frame.
REQ-032 Under reset, the outputs SHALL take these values: neo_data=0, frame_done=0, ready_to_load=1, ready_to_send=1.
REQ-033 Reset SHALL clear both buffers and all counters to zero.
REQ-034 A frame aborted by reset SHALL NOT resume after reset is released.

Structure
REQ-035 Package neopixel_pkg SHALL hold the color_index encoding enum (RED=0, BLUE=1, GREEN=2), the state enum, and default timing constants.
REQ-036 Sub-module neopixel_bit_encoder SHALL generate one bit's waveform from a bit value and a start strobe, assert a done strobe on the last cycle, and be parametrised by T0H, T1H and TBIT.
REQ-037 The top level SHALL hold the buffers, the bit/pixel counters (a $clog2(24*NUM_PIXELS)-bit bit counter) and the latch counter.

Verification
REQ-038 The bench SHALL cover: NUM_PIXELS=5, load pixel0 G=0x80, then send_it -> first bit high 35 cycles/low 28; remaining 119 bits high 18 cycles; frame_done 7560+2500 cycles after SENDING entry.
REQ-039 The bench SHALL cover: load pixel2 R=0xFF during SENDING -> current frame unchanged; next frame shows 0xFF at bits 56..63.
REQ-040 The bench SHALL cover: send_it held high continuously -> back-to-back frames each separated by exactly 2500 low cycles plus 1 IDLE cycle.
REQ-041 The bench SHALL cover: pixel_index=5 or color_index=3 load -> all subsequent frames identical to the prior frame.
REQ-042 The bench SHALL cover: reset asserted at bit 40 -> neo_data=0 immediately; ready_to_send=1; next frame is all-zero bits.
REQ-043 The bench SHALL cover: NUM_PIXELS=1, load_color and send_it in the same cycle -> frame carries the old value; the following frame carries the new value.
